// File: rtl/controle_cafe_pkg.sv
// controle_cafe_pkg: state encoding, display codes and input code points
// shared by the coffee brew controller and its bench.
package controle_cafe_pkg;

    typedef enum logic [2:0] {
        OCIOSO           = 3'd0,
        ANALISE          = 3'd1,
        AGUARDA_CORRECAO = 3'd2,
        AQUECIMENTO      = 3'd3,
        EXTRACAO         = 3'd4,
        CONCLUIDO        = 3'd5,
        FALHA            = 3'd6
    } estado_t;

    localparam logic [3:0] DISP_OCIOSO    = 4'b0000;
    localparam logic [3:0] DISP_ANALISE   = 4'b0001;
    localparam logic [3:0] DISP_AGUARDA   = 4'b0010;
    localparam logic [3:0] DISP_AQUEC     = 4'b0011;
    localparam logic [3:0] DISP_EXTRACAO  = 4'b0100;
    localparam logic [3:0] DISP_CONCLUIDO = 4'b1000;
    localparam logic [3:0] DISP_FALHA     = 4'b1110;

    localparam logic [1:0] SENSOR_ANALISANDO = 2'b00;
    localparam logic [1:0] SENSOR_CORRIGIVEL = 2'b01;
    localparam logic [1:0] SENSOR_OK         = 2'b10;
    localparam logic [1:0] SENSOR_FALHA      = 2'b11;

    localparam logic [1:0] TIPO_CURTO    = 2'b00;
    localparam logic [1:0] TIPO_LONGO    = 2'b01;
    localparam logic [1:0] TIPO_DUPLO    = 2'b10;
    localparam logic [1:0] TIPO_INVALIDO = 2'b11;

    function automatic logic [3:0] codigo_display(input estado_t e);
        case (e)
            ANALISE:          return DISP_ANALISE;
            AGUARDA_CORRECAO: return DISP_AGUARDA;
            AQUECIMENTO:      return DISP_AQUEC;
            EXTRACAO:         return DISP_EXTRACAO;
            CONCLUIDO:        return DISP_CONCLUIDO;
            FALHA:            return DISP_FALHA;
            default:          return DISP_OCIOSO;
        endcase
    endfunction

endpackage

// File: rtl/temporizador_ciclos.sv
// temporizador_ciclos: free-running cycle counter with synchronous clear and
// a terminal flag raised when the count equals the supplied limit.
module temporizador_ciclos #(
    parameter int LARGURA = 16
) (
    input  logic               i_clk,
    input  logic               i_reset_n,
    input  logic               i_limpa,
    input  logic [LARGURA-1:0] i_limite,
    output logic               o_terminal
);

    logic [LARGURA-1:0] r_contagem;

    always_ff @(posedge i_clk) begin
        if (!i_reset_n || i_limpa)
            r_contagem <= '0;
        else
            r_contagem <= r_contagem + LARGURA'(1);
    end

    assign o_terminal = (r_contagem == i_limite);

endmodule

// File: rtl/controle_preparo.sv
// controle_preparo: Moore FSM sequencing sensor check, heating and pump
// extraction for one coffee, with cancel and fault handling.
module controle_preparo
    import controle_cafe_pkg::*;
#(
    parameter int CICLOS_CURTO     = 200,
    parameter int CICLOS_LONGO     = 400,
    parameter int CICLOS_DUPLO     = 600,
    parameter int CICLOS_AQUEC_MAX = 1000,
    parameter int CICLOS_ERRO_MAX  = 500
) (
    input  logic       i_clk,
    input  logic       i_reset_n,
    input  logic       i_botao_inicio,
    input  logic [1:0] i_tipo_cafe,
    input  logic [1:0] i_sensor_status,
    input  logic       i_temp_ok,
    input  logic       i_cancela,
    output logic       o_hab_analise,
    output logic       o_aquecedor,
    output logic       o_bomba,
    output logic       o_pronto,
    output logic       o_ocupado,
    output logic [3:0] o_codigo_display
);

    // Terminal compares fire on the last cycle of a state, hence the -1.
    localparam logic [15:0] LIM_CURTO = 16'(CICLOS_CURTO - 1);
    localparam logic [15:0] LIM_LONGO = 16'(CICLOS_LONGO - 1);
    localparam logic [15:0] LIM_DUPLO = 16'(CICLOS_DUPLO - 1);
    localparam logic [15:0] LIM_AQUEC = 16'(CICLOS_AQUEC_MAX - 1);
    localparam logic [15:0] LIM_ERRO  = 16'(CICLOS_ERRO_MAX - 1);

    estado_t     r_estado;
    estado_t     w_proximo;
    logic [1:0]  r_tipo;
    logic        r_botao_ant;
    logic        w_inicia;
    logic        w_terminal;
    logic [15:0] w_lim_extracao;
    logic [15:0] w_limite;

    assign w_inicia = i_botao_inicio && !r_botao_ant
                   && (i_tipo_cafe != TIPO_INVALIDO) && !i_cancela;

    always_comb begin
        w_lim_extracao = (r_tipo == TIPO_CURTO) ? LIM_CURTO :
                         (r_tipo == TIPO_LONGO) ? LIM_LONGO : LIM_DUPLO;
        w_limite = (r_estado == AGUARDA_CORRECAO) ? LIM_ERRO :
                   (r_estado == AQUECIMENTO)      ? LIM_AQUEC : w_lim_extracao;
    end

    temporizador_ciclos #(.LARGURA(16)) u_temporizador (
        .i_clk      (i_clk),
        .i_reset_n  (i_reset_n),
        .i_limpa    (w_proximo != r_estado),
        .i_limite   (w_limite),
        .o_terminal (w_terminal)
    );

    // Previous-button sample resets to 1 so a button held through reset
    // must be released before it can start a brew.
    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            r_estado    <= OCIOSO;
            r_tipo      <= TIPO_CURTO;
            r_botao_ant <= 1'b1;
        end else begin
            r_estado    <= w_proximo;
            r_botao_ant <= i_botao_inicio;
            if (r_estado == OCIOSO && w_inicia)
                r_tipo <= i_tipo_cafe;
        end
    end

    always_comb begin
        w_proximo = r_estado;
        if (i_cancela && r_estado != OCIOSO)
            w_proximo = OCIOSO;
        else begin
            case (r_estado)
                OCIOSO:
                    w_proximo = w_inicia ? ANALISE : OCIOSO;
                ANALISE:
                    w_proximo = (i_sensor_status == SENSOR_OK)         ? AQUECIMENTO :
                                (i_sensor_status == SENSOR_CORRIGIVEL) ? AGUARDA_CORRECAO :
                                (i_sensor_status == SENSOR_FALHA)      ? FALHA : ANALISE;
                AGUARDA_CORRECAO:
                    w_proximo = (i_sensor_status == SENSOR_OK)                ? AQUECIMENTO :
                                (i_sensor_status == SENSOR_FALHA || w_terminal) ? FALHA :
                                AGUARDA_CORRECAO;
                AQUECIMENTO:
                    w_proximo = i_temp_ok ? EXTRACAO : w_terminal ? FALHA : AQUECIMENTO;
                EXTRACAO:
                    w_proximo = w_terminal ? CONCLUIDO : EXTRACAO;
                CONCLUIDO:
                    w_proximo = OCIOSO;
                FALHA:
                    w_proximo = FALHA;
                default:
                    w_proximo = OCIOSO;
            endcase
        end
    end

    always_comb begin
        o_hab_analise    = (r_estado == ANALISE) || (r_estado == AGUARDA_CORRECAO);
        o_aquecedor      = (r_estado == AQUECIMENTO) || (r_estado == EXTRACAO);
        o_bomba          = (r_estado == EXTRACAO);
        o_pronto         = (r_estado == CONCLUIDO);
        o_ocupado        = (r_estado != OCIOSO) && (r_estado != FALHA);
        o_codigo_display = codigo_display(r_estado);
    end

endmodule

// File: tb/tb_controle_preparo.sv
// tb_controle_preparo: directed scenarios for controle_preparo with small
// cycle parameters; observed outputs packed as {hab,aquec,bomba,pronto,ocup,disp}.
module tb_controle_preparo;

    localparam logic [8:0] O_OCI = 9'b0_0_0_0_0_0000;
    localparam logic [8:0] O_ANA = 9'b1_0_0_0_1_0001;
    localparam logic [8:0] O_AGU = 9'b1_0_0_0_1_0010;
    localparam logic [8:0] O_AQU = 9'b0_1_0_0_1_0011;
    localparam logic [8:0] O_EXT = 9'b0_1_1_0_1_0100;
    localparam logic [8:0] O_CON = 9'b0_0_0_1_1_1000;
    localparam logic [8:0] O_FAL = 9'b0_0_0_0_0_1110;

    logic       clk = 1'b0;
    logic       reset_n, botao, temp_ok, cancela;
    logic [1:0] tipo, sensor;
    logic       hab, aquec, bomba, pronto, ocupado;
    logic [3:0] disp;
    logic [8:0] obs;
    int         n_chk = 0;
    int         n_fail = 0;

    always #5 clk = ~clk;

    assign obs = {hab, aquec, bomba, pronto, ocupado, disp};

    controle_preparo #(
        .CICLOS_CURTO(4), .CICLOS_LONGO(6), .CICLOS_DUPLO(8),
        .CICLOS_AQUEC_MAX(10), .CICLOS_ERRO_MAX(5)
    ) dut (
        .i_clk(clk), .i_reset_n(reset_n), .i_botao_inicio(botao),
        .i_tipo_cafe(tipo), .i_sensor_status(sensor), .i_temp_ok(temp_ok),
        .i_cancela(cancela), .o_hab_analise(hab), .o_aquecedor(aquec),
        .o_bomba(bomba), .o_pronto(pronto), .o_ocupado(ocupado),
        .o_codigo_display(disp)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        botao = 0; tipo = 2'b00; sensor = 2'b00; temp_ok = 0; cancela = 0; reset_n = 1;
        tick();
        tick();
    endtask

    task automatic test_reset();
        logic [8:0] e [8];
        e = '{O_OCI, O_OCI, O_OCI, O_OCI, O_OCI, O_OCI, O_ANA, O_OCI};
        reset_n = 0; botao = 1; tipo = 2'b00; sensor = 2'b00; temp_ok = 0; cancela = 0;
        for (int c = 0; c < 8; c++) begin
            tick();
            n_chk++;
            if (obs !== e[c]) begin
                n_fail++;
                $display("FAIL reset cyc%0d obs=%b exp=%b", c, obs, e[c]);
            end
            if (c == 1) reset_n = 1;
            if (c == 4) botao = 0;
            if (c == 5) botao = 1;
            if (c == 6) cancela = 1;
        end
        idle();
    endtask

    task automatic test_happy();
        logic [8:0] e [12];
        e = '{O_ANA, O_AQU, O_AQU, O_AQU, O_EXT, O_EXT, O_EXT, O_EXT, O_CON, O_OCI, O_OCI, O_OCI};
        tipo = 2'b00; sensor = 2'b10; temp_ok = 0; botao = 1;
        for (int c = 0; c < 12; c++) begin
            tick();
            n_chk++;
            if (obs !== e[c]) begin
                n_fail++;
                $display("FAIL happy cyc%0d obs=%b exp=%b", c, obs, e[c]);
            end
            if (c == 3) temp_ok = 1;
        end
        idle();
    endtask

    task automatic test_long_latched();
        logic [8:0] e [10];
        e = '{O_ANA, O_AQU, O_EXT, O_EXT, O_EXT, O_EXT, O_EXT, O_EXT, O_CON, O_OCI};
        tipo = 2'b01; sensor = 2'b10; temp_ok = 1; botao = 1;
        for (int c = 0; c < 10; c++) begin
            tick();
            n_chk++;
            if (obs !== e[c]) begin
                n_fail++;
                $display("FAIL long_latched cyc%0d obs=%b exp=%b", c, obs, e[c]);
            end
            if (c == 0) tipo = 2'b00;
        end
        idle();
    endtask

    task automatic test_correctable();
        logic [8:0] e [6];
        e = '{O_ANA, O_AGU, O_AGU, O_AGU, O_AQU, O_OCI};
        tipo = 2'b01; sensor = 2'b01; botao = 1;
        for (int c = 0; c < 6; c++) begin
            tick();
            n_chk++;
            if (obs !== e[c]) begin
                n_fail++;
                $display("FAIL correctable cyc%0d obs=%b exp=%b", c, obs, e[c]);
            end
            if (c == 3) sensor = 2'b10;
            if (c == 4) cancela = 1;
        end
        idle();
    endtask

    task automatic test_error_timeout();
        logic [8:0] e [9];
        e = '{O_ANA, O_AGU, O_AGU, O_AGU, O_AGU, O_AGU, O_FAL, O_FAL, O_OCI};
        tipo = 2'b00; sensor = 2'b01; botao = 1;
        for (int c = 0; c < 9; c++) begin
            tick();
            n_chk++;
            if (obs !== e[c]) begin
                n_fail++;
                $display("FAIL error_timeout cyc%0d obs=%b exp=%b", c, obs, e[c]);
            end
            if (c == 7) cancela = 1;
        end
        idle();
    endtask

    task automatic test_sensor_fault();
        logic [8:0] e [5];
        e = '{O_ANA, O_ANA, O_FAL, O_FAL, O_OCI};
        tipo = 2'b10; sensor = 2'b00; botao = 1;
        for (int c = 0; c < 5; c++) begin
            tick();
            n_chk++;
            if (obs !== e[c]) begin
                n_fail++;
                $display("FAIL sensor_fault cyc%0d obs=%b exp=%b", c, obs, e[c]);
            end
            if (c == 1) sensor = 2'b11;
            if (c == 3) cancela = 1;
        end
        idle();
    endtask

    task automatic test_heat_timeout();
        logic [8:0] e [14];
        e = '{O_ANA, O_AQU, O_AQU, O_AQU, O_AQU, O_AQU, O_AQU, O_AQU, O_AQU, O_AQU, O_AQU,
              O_FAL, O_FAL, O_OCI};
        tipo = 2'b00; sensor = 2'b10; temp_ok = 0; botao = 1;
        for (int c = 0; c < 14; c++) begin
            tick();
            n_chk++;
            if (obs !== e[c]) begin
                n_fail++;
                $display("FAIL heat_timeout cyc%0d obs=%b exp=%b", c, obs, e[c]);
            end
            if (c == 12) cancela = 1;
        end
        idle();
    endtask

    task automatic test_cancel_extraction();
        logic [8:0] e [8];
        e = '{O_ANA, O_AQU, O_EXT, O_EXT, O_EXT, O_OCI, O_OCI, O_OCI};
        tipo = 2'b10; sensor = 2'b10; temp_ok = 1; botao = 1;
        for (int c = 0; c < 8; c++) begin
            tick();
            n_chk++;
            if (obs !== e[c]) begin
                n_fail++;
                $display("FAIL cancel_extraction cyc%0d obs=%b exp=%b", c, obs, e[c]);
            end
            if (c == 4) cancela = 1;
            if (c == 5) cancela = 0;
        end
        idle();
    endtask

    task automatic test_invalid_type();
        logic [8:0] e [7];
        e = '{O_OCI, O_OCI, O_OCI, O_OCI, O_OCI, O_ANA, O_OCI};
        tipo = 2'b11; sensor = 2'b00; botao = 1;
        for (int c = 0; c < 7; c++) begin
            tick();
            n_chk++;
            if (obs !== e[c]) begin
                n_fail++;
                $display("FAIL invalid_type cyc%0d obs=%b exp=%b", c, obs, e[c]);
            end
            if (c == 2) tipo = 2'b00;
            if (c == 3) botao = 0;
            if (c == 4) botao = 1;
            if (c == 5) cancela = 1;
        end
        idle();
    endtask

    task automatic test_reset_midbrew();
        logic [8:0] e [9];
        e = '{O_ANA, O_AQU, O_AQU, O_OCI, O_OCI, O_OCI, O_OCI, O_ANA, O_OCI};
        tipo = 2'b01; sensor = 2'b10; temp_ok = 0; botao = 1;
        for (int c = 0; c < 9; c++) begin
            tick();
            n_chk++;
            if (obs !== e[c]) begin
                n_fail++;
                $display("FAIL reset_midbrew cyc%0d obs=%b exp=%b", c, obs, e[c]);
            end
            if (c == 2) begin
                reset_n = 0;
                cancela = 1;
            end
            if (c == 3) begin
                reset_n = 1;
                cancela = 0;
            end
            if (c == 5) botao = 0;
            if (c == 6) botao = 1;
            if (c == 7) cancela = 1;
        end
        idle();
    endtask

    initial begin
        test_reset();
        test_happy();
        test_long_latched();
        test_correctable();
        test_error_timeout();
        test_sensor_fault();
        test_heat_timeout();
        test_cancel_extraction();
        test_invalid_type();
        test_reset_midbrew();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/controle_preparo.md
CONTROLE_PREPARO -- requirements
Module: controle_preparo

Interface
REQ-001 Parameter CICLOS_CURTO, 200: pump-on cycles for a short coffee.
REQ-002 Parameter CICLOS_LONGO, 400: pump-on cycles for a long coffee.
REQ-003 Parameter CICLOS_DUPLO, 600: pump-on cycles for a double coffee.
REQ-004 Parameter CICLOS_AQUEC_MAX, 1000: heating timeout in cycles.
REQ-005 Parameter CICLOS_ERRO_MAX, 500: maximum wait in cycles for the user to correct a sensor error.
REQ-006 CLK  in  1  single clock; all state changes on its rising edge.
REQ-007 RESET_N  in  1  reset, synchronous and active-low.
REQ-008 BOTAO_INICIO  in  1  start button, level; a 0->1 edge requests a brew.
REQ-009 TIPO_CAFE  in  2  drink select: 00 short, 01 long, 10 double, 11 invalid.
REQ-010 SENSOR_STATUS  in  2  sensor checker result: 00 analysing, 01 correctable error, 10 no errors, 11 sensor fault.
REQ-011 TEMP_OK  in  1  heater at brewing temperature.
REQ-012 CANCELA  in  1  abort / fault acknowledge.
REQ-013 HAB_ANALISE  out  1  enables the sensor checker.
REQ-014 AQUECEDOR  out  1  heater on.
REQ-015 BOMBA  out  1  pump on.
REQ-016 PRONTO  out  1  one-cycle brew-complete pulse.
REQ-017 OCUPADO  out  1  high in every state except OCIOSO and FALHA.
REQ-018 CODIGO_DISPLAY  out  4  status code for the display.

Function
REQ-019 States SHALL be OCIOSO, ANALISE, AGUARDA_CORRECAO, AQUECIMENTO, EXTRACAO, CONCLUIDO and FALHA.
REQ-020 All outputs SHALL be decoded from the registered state only (Moore).
REQ-021 HAB_ANALISE SHALL be 1 only in ANALISE and AGUARDA_CORRECAO.
REQ-022 AQUECEDOR SHALL be 1 in AQUECIMENTO and EXTRACAO.
REQ-023 BOMBA SHALL be 1 only in EXTRACAO.
REQ-024 PRONTO SHALL be 1 only in CONCLUIDO.
REQ-025 CODIGO_DISPLAY SHALL be: OCIOSO 0000, ANALISE 0001, AGUARDA_CORRECAO 0010, AQUECIMENTO 0011, EXTRACAO 0100, CONCLUIDO 1000, FALHA 1110.
REQ-026 OCIOSO -> ANALISE SHALL occur when all hold: BOTAO_INICIO edge (current 1, previous-cycle sample 0), TIPO_CAFE != 11, CANCELA = 0; TIPO_CAFE SHALL be latched on that edge.
REQ-027 A start edge with TIPO_CAFE = 11 SHALL be ignored, and a held button SHALL never retrigger.
REQ-028 ANALISE transitions SHALL be: status 10 -> AQUECIMENTO; 01 -> AGUARDA_CORRECAO; 11 -> FALHA; 00 -> stay.
REQ-029 AGUARDA_CORRECAO transitions SHALL be: status 10 -> AQUECIMENTO; 11 -> FALHA; otherwise FALHA when the cycle counter reaches CICLOS_ERRO_MAX-1.
REQ-030 AQUECIMENTO SHALL go to EXTRACAO when TEMP_OK = 1, else to FALHA when the counter reaches CICLOS_AQUEC_MAX-1; TEMP_OK wins if both occur in the same cycle.
REQ-031 EXTRACAO SHALL last exactly N cycles (N selected by the latched type), then go to CONCLUIDO; TEMP_OK is ignored in EXTRACAO.
REQ-032 CONCLUIDO SHALL last one cycle, then go to OCIOSO.
REQ-033 FALHA SHALL hold until CANCELA = 1, then go to OCIOSO.
REQ-034 CANCELA = 1 in any busy state SHALL force OCIOSO on the next edge, with priority over every other transition.
REQ-035 The cycle counter SHALL be 16 bits wide, cleared on every state change, and incremented otherwise; parameters above 65535 are illegal.

Reset
REQ-036 RESET_N = 0 at a clock edge SHALL set: state OCIOSO, counter 0, latched type 00, previous-button register 1, and all outputs 0 / display 0000.
REQ-037 Reset asserted mid-brew SHALL override CANCELA and all transitions; after release, a button held through reset SHALL NOT start a brew until it is released and pressed again.

Structure
REQ-038 Package controle_cafe_pkg SHALL hold the state encoding, display codes, SENSOR_STATUS codes and TIPO_CAFE codes.
REQ-039 The counter with clear and terminal-compare SHALL be a sub-module named temporizador_ciclos.

Verification
(All scenarios use CICLOS_CURTO=4, CICLOS_LONGO=6, CICLOS_DUPLO=8, CICLOS_AQUEC_MAX=10, CICLOS_ERRO_MAX=5.)
REQ-040 Happy path: TIPO_CAFE=00, button edge, status 10, TEMP_OK=1 after 3 cycles -> BOMBA high exactly 4 cycles, then PRONTO high 1 cycle, then display 0000.
REQ-041 Correctable error: status 01 for 3 cycles, then 10 -> display 0001, 0010, then 0011 with no FALHA; with status held at 01 instead -> FALHA after 5 cycles in AGUARDA_CORRECAO, display 1110.
REQ-042 Heat timeout: TEMP_OK=0 -> FALHA after 10 cycles in AQUECIMENTO with AQUECEDOR dropping to 0; then CANCELA=1 -> OCIOSO.
REQ-043 Cancel mid-extraction: TIPO_CAFE=10, CANCELA=1 on the 3rd BOMBA cycle -> BOMBA=0 and display 0000 on the next edge, and no PRONTO pulse.
REQ-044 Edge cases:
- TIPO_CAFE=11 with a button edge -> stays in OCIOSO.
- Button held through CONCLUIDO -> no restart.
- Button held through reset -> no start until re-pressed.
- RESET_N=0 during AQUECIMENTO -> all outputs 0 on the next edge.
